// File: rtl/can_pkg.sv
`default_nettype none
// ============================================================================
// Module      : can_pkg
// Description : Shared constants and types for the CAN receive-frame FIFO:
//               register offsets, STATUS/command bit positions, entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package can_pkg;

  // Register word offsets on the TinyQV bus
  localparam logic [1:0] CAN_REG_ID   = 2'd0;
  localparam logic [1:0] CAN_REG_STAT = 2'd1;
  localparam logic [1:0] CAN_REG_D0   = 2'd2;
  localparam logic [1:0] CAN_REG_D1   = 2'd3;

  // STATUS read-back bit positions
  localparam int STAT_DLC_LSB  = 0;
  localparam int STAT_EMPTY    = 4;
  localparam int STAT_FULL     = 5;
  localparam int STAT_OVF      = 6;
  localparam int STAT_IRQEN    = 7;
  localparam int STAT_DROP_LSB = 8;
  localparam int STAT_CNT_LSB  = 16;

  // STATUS write command bit positions (self-clearing, never stored)
  localparam int CMD_IRQEN   = 7;
  localparam int CMD_POP     = 8;
  localparam int CMD_CLR_OVF = 9;
  localparam int CMD_FLUSH   = 10;

  // One stored frame: ext, rtr, id29, dlc4, data64
  localparam int ENTRY_W = 99;

  typedef struct packed {
    logic        ext;
    logic        rtr;
    logic [28:0] id;
    logic [3:0]  dlc;
    logic [63:0] data;
  } can_entry_t;

  // Increment that sticks at 255 instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/can_fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module      : can_fifo_ptr
// Description : Read/write pointer and occupancy tracking for the CAN RX FIFO.
//               Arbitrates push, pop and flush; a full FIFO still accepts a
//               push when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module can_fifo_ptr #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_req,
  input  logic                       pop_req,
  input  logic                       flush,
  output logic [$clog2(DEPTH)-1:0]   wr_ptr,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       push_ok,
  output logic                       drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          pop_ok;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;

  // Arbitration and next-pointer computation; flush overrides everything
  always_comb begin
    push_ok  = push_req & ~flush & (~full | pop_req);
    pop_ok   = pop_req & ~empty & ~flush;
    drop     = push_req & ~flush & full & ~pop_req;
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/can_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : can_rx_fifo
// Description : Receive-frame buffer behind the CAN receiver. Stores valid
//               frames in a DEPTH-entry FIFO, exposes the head entry and a
//               STATUS/command word on a 4-word bus window, raises irq while
//               frames are pending.
// Revision    : 1.0 - initial release
// ============================================================================
module can_rx_fifo
  import can_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [28:0] in_id,
  input  logic        in_ext,
  input  logic        in_rtr,
  input  logic [3:0]  in_dlc,
  input  logic [63:0] in_data,
  input  logic        cs,
  input  logic        we,
  input  logic [1:0]  rs,
  input  logic [31:0] d,
  output logic [31:0] q,
  output logic        irq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push_ok, drop;
  logic          stat_wr, cmd_pop, cmd_clr, cmd_flush;

  logic          ovf_q,   ovf_d;
  logic [7:0]    drop_q,  drop_d;
  logic          irqen_q, irqen_d;

  can_entry_t    mem_q [DEPTH];
  can_entry_t    head;
  logic [31:0]   status;

  assign stat_wr   = cs & we & (rs == CAN_REG_STAT);
  assign cmd_pop   = stat_wr & d[CMD_POP];
  assign cmd_clr   = stat_wr & d[CMD_CLR_OVF];
  assign cmd_flush = stat_wr & d[CMD_FLUSH];

  can_fifo_ptr #(
    .DEPTH (DEPTH)
  ) u_ptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_req (in_valid),
    .pop_req  (cmd_pop),
    .flush    (cmd_flush),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .push_ok  (push_ok),
    .drop     (drop)
  );

  // Entry storage; contents are meaningless until written, so no reset
  always_ff @(posedge clk) begin
    if (rst_n && push_ok) begin
      mem_q[wr_ptr] <= '{ext: in_ext, rtr: in_rtr, id: in_id,
                         dlc: in_dlc, data: in_data};
    end
  end

  // Overflow flag, drop counter and irq enable; a drop in the same cycle as
  // CLR_OVF is still recorded so no lost frame goes unreported
  always_comb begin
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    irqen_d = irqen_q;
    if (stat_wr) irqen_d = d[CMD_IRQEN];
    if (cmd_clr) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
    if (drop) begin
      ovf_d  = 1'b1;
      drop_d = sat_inc8(drop_d);
    end
  end

  // Control/status registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q   <= 1'b0;
      drop_q  <= '0;
      irqen_q <= 1'b0;
    end else begin
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      irqen_q <= irqen_d;
    end
  end

  // Head entry gated to zero when empty (storage may hold stale data), then
  // STATUS assembly and read mux
  always_comb begin
    head   = empty ? '0 : mem_q[rd_ptr];
    status = '0;
    status[STAT_DLC_LSB +: 4]  = head.dlc;
    status[STAT_EMPTY]         = empty;
    status[STAT_FULL]          = full;
    status[STAT_OVF]           = ovf_q;
    status[STAT_IRQEN]         = irqen_q;
    status[STAT_DROP_LSB +: 8] = drop_q;
    status[STAT_CNT_LSB +: CW] = count;
    q = '0;
    if (cs) begin
      case (rs)
        CAN_REG_ID:   q = {head.ext, head.rtr, 1'b0, head.id};
        CAN_REG_STAT: q = status;
        CAN_REG_D0:   q = head.data[31:0];
        default:      q = head.data[63:32];
      endcase
    end
  end

  assign irq = irqen_q & ~empty;

endmodule
`default_nettype wire

// File: tb/tb_can_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_can_rx_fifo
// Description : Self-checking bench for can_rx_fifo. A queue of expected
//               frames plus flag model is updated as stimulus is driven and
//               compared against the bus read-back.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_can_rx_fifo;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic        ext;
    logic        rtr;
    logic [28:0] id;
    logic [3:0]  dlc;
    logic [63:0] data;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [28:0] in_id = '0;
  logic        in_ext = 1'b0;
  logic        in_rtr = 1'b0;
  logic [3:0]  in_dlc = '0;
  logic [63:0] in_data = '0;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  rs = '0;
  logic [31:0] d = '0;
  logic [31:0] q;
  logic        irq;

  int checks = 0;
  int failures = 0;

  frame_t     sb[$];
  logic       m_ovf = 1'b0;
  logic [7:0] m_drop = '0;
  logic       m_irqen = 1'b0;

  always #5 clk = ~clk;

  can_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_id(in_id),
    .in_ext(in_ext), .in_rtr(in_rtr), .in_dlc(in_dlc), .in_data(in_data),
    .cs(cs), .we(we), .rs(rs), .d(d), .q(q), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic frame_t mk(input logic [28:0] id, input logic ext, input logic rtr,
                                input logic [3:0] dlc, input logic [63:0] data);
    frame_t f;
    f.ext = ext; f.rtr = rtr; f.id = id; f.dlc = dlc; f.data = data;
    return f;
  endfunction

  // One clock of stimulus: optional frame strobe and optional STATUS write.
  // The reference model is updated from the same stimulus.
  task automatic drive(input logic v, input frame_t f, input logic w, input logic [31:0] wd);
    bit was_full;
    @(negedge clk);
    in_valid = v; in_id = f.id; in_ext = f.ext; in_rtr = f.rtr;
    in_dlc = f.dlc; in_data = f.data;
    cs = w; we = w; rs = 2'd1; d = wd;
    if (w) m_irqen = wd[7];
    if (w && wd[9]) begin
      m_ovf = 1'b0;
      m_drop = '0;
    end
    if (w && wd[10]) begin
      sb.delete();
    end else begin
      was_full = (sb.size() == DEPTH);
      if (w && wd[8] && sb.size() > 0) void'(sb.pop_front());
      if (v) begin
        if (!was_full || (w && wd[8])) sb.push_back(f);
        else begin
          m_ovf = 1'b1;
          if (m_drop != 8'hFF) m_drop++;
        end
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; cs = 1'b0; we = 1'b0; d = '0;
  endtask

  task automatic rd(input logic [1:0] r, output logic [31:0] v);
    cs = 1'b1; we = 1'b0; rs = r;
    #1;
    v = q;
    cs = 1'b0;
    #1;
  endtask

  // Compare all four registers and irq against the model
  task automatic verify(input string tag);
    logic [31:0] v, es;
    frame_t h;
    h = (sb.size() > 0) ? sb[0] : '0;
    es = '0;
    es[3:0]   = h.dlc;
    es[4]     = (sb.size() == 0);
    es[5]     = (sb.size() == DEPTH);
    es[6]     = m_ovf;
    es[7]     = m_irqen;
    es[15:8]  = m_drop;
    es[20:16] = 5'(sb.size());
    rd(2'd1, v); check({tag, ".stat"}, v, es);
    rd(2'd0, v); check({tag, ".id"}, v, {h.ext, h.rtr, 1'b0, h.id});
    rd(2'd2, v); check({tag, ".d0"}, v, h.data[31:0]);
    rd(2'd3, v); check({tag, ".d1"}, v, h.data[63:32]);
    check({tag, ".irq"}, {31'b0, irq}, {31'b0, m_irqen & (sb.size() > 0)});
  endtask

  initial begin
    logic [31:0] v;
    frame_t none;
    none = '0;

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset.q_idle", q, 32'h0);
    check("reset.irq", {31'b0, irq}, 32'h0);
    rd(2'd1, v); check("reset.stat", v, 32'h0000_0010);
    rd(2'd0, v); check("reset.id", v, 32'h0);

    // Single standard frame, irq enable, then pop
    drive(1'b0, none, 1'b1, 32'h0000_0080);
    drive(1'b1, mk(29'h123, 1'b0, 1'b0, 4'd2, 64'h0000_0000_0000_BBAA), 1'b0, 32'h0);
    rd(2'd0, v); check("one.id", v, 32'h0000_0123);
    rd(2'd2, v); check("one.d0", v, 32'h0000_BBAA);
    verify("one");
    drive(1'b0, none, 1'b1, 32'h0000_0180);
    verify("one_pop");

    // Overflow: DEPTH+2 frames
    for (int i = 1; i <= DEPTH + 2; i++)
      drive(1'b1, mk(29'(i), 1'b0, 1'b0, 4'(i), {32'(i * 3), 32'(i * 7)}), 1'b0, 32'h0);
    rd(2'd1, v); check("ovf.stat", v, 32'h0004_02E1);
    verify("ovf");
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, none, 1'b1, 32'h0000_0180);
      verify("ovf_pop");
    end

    // Full FIFO with same-cycle push and pop
    drive(1'b0, none, 1'b1, 32'h0000_0280);
    for (int i = 0; i < DEPTH; i++)
      drive(1'b1, mk(29'(16 + i), 1'b0, 1'b0, 4'd8, {32'(i), 32'hCAFE_0000}), 1'b0, 32'h0);
    drive(1'b1, mk(29'h77, 1'b0, 1'b0, 4'd1, 64'h55), 1'b1, 32'h0000_0180);
    verify("pushpop");
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, none, 1'b1, 32'h0000_0180);
      verify("pushpop_drain");
    end

    // Extended remote frame
    drive(1'b1, mk(29'h1ABC_DEF0, 1'b1, 1'b1, 4'd0, 64'h0), 1'b0, 32'h0);
    rd(2'd0, v); check("ext.id", v, 32'hDABC_DEF0);
    drive(1'b0, none, 1'b1, 32'h0000_0180);

    // Flush with three entries and a concurrent frame
    for (int i = 0; i < 3; i++)
      drive(1'b1, mk(29'(40 + i), 1'b0, 1'b0, 4'd4, 64'(i)), 1'b0, 32'h0);
    drive(1'b1, mk(29'h99, 1'b0, 1'b0, 4'd3, 64'h9), 1'b1, 32'h0000_0480);
    verify("flush");

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      logic [31:0] wd;
      wd = {21'b0, ($urandom_range(0, 19) == 0), $urandom_range(0, 7) == 0,
            $urandom_range(0, 2) != 0, 1'b1, 7'b0};
      drive($urandom_range(0, 1) == 1,
            mk(29'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
               {$urandom, $urandom}),
            $urandom_range(0, 1) == 1, wd);
      verify("rand");
    end

    // Reset mid-operation with a coincident frame
    drive(1'b0, none, 1'b1, 32'h0000_0500);
    drive(1'b1, mk(29'h5, 1'b0, 1'b0, 4'd1, 64'h1), 1'b0, 32'h0);
    drive(1'b1, mk(29'h6, 1'b0, 1'b0, 4'd1, 64'h2), 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    sb.delete(); m_ovf = 1'b0; m_drop = '0; m_irqen = 1'b0;
    rd(2'd1, v); check("rst.stat", v, 32'h0000_0010);
    verify("rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
